// File: rtl/zfifo_ctrl_if.sv
// zfifo_ctrl_if: signal bundle between the FIFO controller, its datapath neighbours and the
// dual-port RAM macro.
//   slave  modport: controller view (drives push_ready, pop side, RAM command, flags)
//   master modport: environment view (drives flush, push side, pop_ready, RAM read data)
// Signals:
//   flush                      synchronous clear
//   push_valid/ready/data      upstream valid/ready handshake
//   pop_valid/ready/data       downstream first-word-fall-through handshake
//   ram_wr_en/addr/data        RAM write port
//   ram_rd_en/addr, ram_rd_data RAM read port (data valid the cycle after ram_rd_en)
//   level, empty, almost_full  registered occupancy flags
interface zfifo_ctrl_if #(
  parameter int unsigned log2_depth = 6,
  parameter int unsigned width      = 8
) ();
  logic                  flush;
  logic                  push_valid;
  logic                  push_ready;
  logic [width-1:0]      push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [width-1:0]      pop_data;
  logic                  ram_wr_en;
  logic [log2_depth-1:0] ram_wr_addr;
  logic [width-1:0]      ram_wr_data;
  logic                  ram_rd_en;
  logic [log2_depth-1:0] ram_rd_addr;
  logic [width-1:0]      ram_rd_data;
  logic [log2_depth:0]   level;
  logic                  empty;
  logic                  almost_full;

  modport slave (
    input  flush, push_valid, push_data, pop_ready, ram_rd_data,
    output push_ready, pop_valid, pop_data, ram_wr_en, ram_wr_addr, ram_wr_data,
           ram_rd_en, ram_rd_addr, level, empty, almost_full
  );

  modport master (
    output flush, push_valid, push_data, pop_ready, ram_rd_data,
    input  push_ready, pop_valid, pop_data, ram_wr_en, ram_wr_addr, ram_wr_data,
           ram_rd_en, ram_rd_addr, level, empty, almost_full
  );
endinterface

// File: rtl/zfifo_ctrl.sv
// zfifo_ctrl: first-word-fall-through FIFO controller around a dual-port RAM with a 1-cycle
// registered read. Owns write/read pointers, RAM occupancy, one in-flight read flag and a
// 2-entry output stage (head + skid), giving a total capacity of depth+2 words.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  zfifo_ctrl_if.slave: push/pop handshakes, RAM command/data, level/empty/almost_full
module zfifo_ctrl #(
  parameter int unsigned depth        = 64,
  parameter int unsigned log2_depth   = 6,
  parameter int unsigned width        = 8,
  parameter int unsigned afull_thresh = 56
) (
  input logic         clk,
  input logic         rst,
  zfifo_ctrl_if.slave bus
);

  localparam int unsigned cnt_w = log2_depth + 1;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } stage_e;

  logic [log2_depth-1:0] wrptr_q, wrptr_d;
  logic [log2_depth-1:0] rdptr_q, rdptr_d;
  logic [cnt_w-1:0]      ram_count_q, ram_count_d;
  logic                  inflight_q, inflight_d;
  stage_e                stage_q, stage_d;
  logic [width-1:0]      head_q, head_d;
  logic [width-1:0]      skid_q, skid_d;
  logic [cnt_w-1:0]      level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;

  logic       push_ready;
  logic       pop_valid;
  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [1:0] stage_cnt;
  logic [1:0] stage_cnt_d;

  always_comb begin
    stage_cnt = 2'd0;
    unique case (stage_q)
      StOne:   stage_cnt = 2'd1;
      StTwo:   stage_cnt = 2'd2;
      default: stage_cnt = 2'd0;
    endcase
  end

  assign push_ready = (ram_count_q != cnt_w'(depth)) & ~bus.flush;
  assign pop_valid  = (stage_q != StEmpty);
  assign push       = bus.push_valid & push_ready;
  assign pop        = pop_valid & bus.pop_ready;

  // Issue a read only if the word will have a stage slot when it lands: words already in
  // the stage plus the one in flight, minus the one leaving now, must be below 2.
  assign rd_issue = (ram_count_q != '0) &
                    (({1'b0, stage_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop})) &
                    ~bus.flush;

  always_comb begin
    wrptr_d     = wrptr_q;
    rdptr_d     = rdptr_q;
    ram_count_d = ram_count_q;
    inflight_d  = inflight_q;
    stage_d     = stage_q;
    head_d      = head_q;
    skid_d      = skid_q;

    if (bus.flush) begin
      // Any read still in flight is dropped by clearing inflight.
      wrptr_d     = '0;
      rdptr_d     = '0;
      ram_count_d = '0;
      inflight_d  = 1'b0;
      stage_d     = StEmpty;
      head_d      = '0;
      skid_d      = '0;
    end else begin
      wrptr_d     = wrptr_q + log2_depth'(push);
      rdptr_d     = rdptr_q + log2_depth'(rd_issue);
      ram_count_d = ram_count_q + cnt_w'(push) - cnt_w'(rd_issue);
      inflight_d  = rd_issue;

      // inflight_q means ram_rd_data carries a word this cycle.
      unique case (stage_q)
        StEmpty: begin
          if (inflight_q) begin
            stage_d = StOne;
            head_d  = bus.ram_rd_data;
          end
        end
        StOne: begin
          if (inflight_q && pop) begin
            head_d = bus.ram_rd_data;
          end else if (inflight_q) begin
            stage_d = StTwo;
            skid_d  = bus.ram_rd_data;
          end else if (pop) begin
            stage_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            stage_d = StOne;
            head_d  = skid_q;
          end
        end
        default: stage_d = StEmpty;
      endcase
    end

    stage_cnt_d = 2'd0;
    unique case (stage_d)
      StOne:   stage_cnt_d = 2'd1;
      StTwo:   stage_cnt_d = 2'd2;
      default: stage_cnt_d = 2'd0;
    endcase

    level_d = ram_count_d + cnt_w'(inflight_d) + cnt_w'(stage_cnt_d);
    empty_d = (level_d == '0);
    afull_d = (level_d >= cnt_w'(afull_thresh));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      stage_q     <= StEmpty;
      head_q      <= '0;
      skid_q      <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      stage_q     <= stage_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
    end
  end

  assign bus.push_ready  = push_ready;
  assign bus.pop_valid   = pop_valid;
  assign bus.pop_data    = head_q;
  assign bus.ram_wr_en   = push;
  assign bus.ram_wr_addr = wrptr_q;
  assign bus.ram_wr_data = bus.push_data;
  assign bus.ram_rd_en   = rd_issue;
  assign bus.ram_rd_addr = rdptr_q;
  assign bus.level       = level_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = afull_q;

endmodule
